// File: rtl/s_compute_acoustivdy_pkg.sv
// Shared constants and FSM encoding for the acoustic vdy y-difference stage.
// Also imported by the multiplier wrapper and the bench.
package s_compute_acoustivdy_pkg;

  localparam int unsigned DefDataW = 14;
  localparam int unsigned DefCoefW = 8;
  localparam int unsigned DefDiffW = DefDataW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Counter width that stays legal for a dimension of 1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/s_compute_acoustivdy_linebuf.sv
// One-row line buffer: single-port RAM, read-before-write, registered read data
// that holds while re_i is low so a stalled pipeline keeps its neighbour sample.
module s_compute_acoustivdy_linebuf
  import s_compute_acoustivdy_pkg::*;
#(
  parameter int unsigned NX     = 64,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned AddrW  = cnt_w(NX)
) (
  input  logic              clk_i,
  input  logic [AddrW-1:0]  addr_i,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [NX];
  logic [DATA_W-1:0] rdata_q;

  // Both assignments are non-blocking, so the read returns the pre-write word.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem[addr_i];
    end
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/s_compute_acoustivdy_diff.sv
// Streaming y-direction difference dp = p[y][x] - p[y-1][x] (zero neighbour on row 0),
// two-stage pipeline with a latched coefficient for the downstream vdy multiplier.
module s_compute_acoustivdy_diff
  import s_compute_acoustivdy_pkg::*;
#(
  parameter int unsigned NX     = 64,
  parameter int unsigned NY     = 64,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned COEF_W = DefCoefW
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic [COEF_W-1:0] coef,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W:0]   out_diff,
  output logic [COEF_W-1:0] out_coef,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned XW    = cnt_w(NX);
  localparam int unsigned YW    = cnt_w(NY);
  localparam int unsigned DiffW = DATA_W + 1;

  state_e state_q, state_d;

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [COEF_W-1:0] coef_q, coef_d;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_y0_q, s1_y0_d;
  logic              s1_last_q, s1_last_d;

  logic              out_valid_q, out_valid_d;
  logic [DiffW-1:0]  out_diff_q, out_diff_d;
  logic              out_last_q, out_last_d;

  logic              stall, advance, accept, last_accept, run_st, start_acc;
  logic [DATA_W-1:0] rd_data;
  logic [DiffW-1:0]  p_ext, nb_ext, diff;

  // Handshake and pipeline control
  assign stall       = out_valid_q && !out_ready;
  assign advance     = !stall;
  assign accept      = in_valid && in_ready;
  assign start_acc   = (state_q == StIdle) && ap_start;
  assign last_accept = (x_q == XW'(NX - 1)) && (y_q == YW'(NY - 1));

  // FSM: state register
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ap_start) state_d = StRun;
      StRun:   if (accept && last_accept) state_d = StDrain;
      StDrain: if (!s1_valid_q && out_valid_q && out_ready && out_last_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ap_idle = 1'b0;
    ap_done = 1'b0;
    run_st  = 1'b0;
    unique case (state_q)
      StIdle:  ap_idle = 1'b1;
      StRun:   run_st  = 1'b1;
      StDrain: ;
      StDone:  ap_done = 1'b1;
      default: ap_idle = 1'b1;
    endcase
  end

  assign in_ready = run_st && !stall;

  // Position counters and coefficient latch
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    coef_d = coef_q;
    if (start_acc) begin
      x_d    = '0;
      y_d    = '0;
      coef_d = coef;
    end else if (accept) begin
      if (x_q == XW'(NX - 1)) begin
        x_d = '0;
        y_d = last_accept ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      coef_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      coef_q <= coef_d;
    end
  end

  // Stage 1: sample register alongside the line-buffer read
  s_compute_acoustivdy_linebuf #(
    .NX     (NX),
    .DATA_W (DATA_W),
    .AddrW  (XW)
  ) u_linebuf (
    .clk_i   (ap_clk),
    .addr_i  (x_q),
    .re_i    (advance),
    .we_i    (accept),
    .wdata_i (in_data),
    .rdata_o (rd_data)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_y0_d    = s1_y0_q;
    s1_last_d  = s1_last_q;
    if (advance) begin
      s1_valid_d = accept;
      s1_data_d  = in_data;
      s1_y0_d    = (y_q == '0);
      s1_last_d  = accept && last_accept;
    end
  end

  // Stage 2: exact signed subtract one bit wider than the samples
  assign p_ext  = {s1_data_q[DATA_W-1], s1_data_q};
  assign nb_ext = s1_y0_q ? '0 : {rd_data[DATA_W-1], rd_data};
  assign diff   = p_ext - nb_ext;

  always_comb begin
    out_valid_d = out_valid_q;
    out_diff_d  = out_diff_q;
    out_last_d  = out_last_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_diff_d = diff;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_y0_q     <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_diff_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_y0_q     <= s1_y0_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_diff_q  <= out_diff_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_diff  = out_diff_q;
  assign out_last  = out_last_q;
  assign out_coef  = coef_q;

endmodule
